fetch_queue: RTL and testbench



---
 rtl/fetch_queue_if.sv | 10 +
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response channel between fetch and imem.
interface fetch_queue_if;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemAddr;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  modport master(output imemReqValid, imemAddr, input imemReqReady, imemRspValid, imemRspData);
  modport slave(input imemReqValid, imemAddr, output imemReqReady, imemRspValid, imemRspData);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, credit-limited imem request issue and instruction FIFO for decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master imem,
  input  logic          stallD,
  input  logic          redirectE,
  input  logic [31:0]   pcTargetE,
  output logic [31:0]   instrD,
  output logic [31:0]   pcD,
  output logic [31:0]   pcPlus4D,
  output logic          validD
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_count, r_out, r_disc;
  logic [AW-1:0] r_hd, r_tl, r_trd, r_twr;
  logic [31:0]   r_word [QDEPTH];
  logic [31:0]   r_wpc  [QDEPTH];
  logic [31:0]   r_tag  [QDEPTH];
  logic w_have, w_byp, w_req, w_acc, w_keep, w_pop, w_fpop, w_push;
  assign w_have = r_count != '0;
`ifdef FETCH_BYPASS_EN
  assign w_byp = !w_have && r_disc == '0 && imem.imemRspValid;
`else
  assign w_byp = 1'b0;
`endif
  assign validD   = w_have || w_byp;
  assign instrD   = w_have ? r_word[r_hd] : w_byp ? imem.imemRspData : NOP;
  assign pcD      = w_have ? r_wpc[r_hd] : w_byp ? r_tag[r_trd] : 32'd0;
  assign pcPlus4D = pcD + 32'd4;
  // credits cover both buffered words and requests still in flight
  assign w_req  = !rst && !redirectE && ({1'b0, r_count} + {1'b0, r_out} < (CW+1)'(QDEPTH));
  assign w_acc  = w_req && imem.imemReqReady;
  assign w_keep = imem.imemRspValid && r_disc == '0;
  assign w_pop  = validD && !stallD && !redirectE;
  assign w_fpop = w_pop && w_have;
  assign w_push = w_keep && !redirectE && !(w_byp && w_pop);
  assign imem.imemReqValid = w_req;
  assign imem.imemAddr     = r_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_out   <= '0;
      r_disc  <= '0;
      r_hd    <= '0;
      r_tl    <= '0;
      r_trd   <= '0;
      r_twr   <= '0;
    end else if (redirectE) begin
      r_pc    <= {pcTargetE[31:2], 2'b00};
      r_count <= '0;
      r_out   <= '0;
      r_disc  <= r_disc + r_out - CW'(imem.imemRspValid);
      r_hd    <= '0;
      r_tl    <= '0;
      r_trd   <= '0;
      r_twr   <= '0;
    end else begin
      if (w_acc) r_pc <= r_pc + 32'd4;
      if (w_acc) r_twr <= r_twr + AW'(1);
      if (w_keep) r_trd <= r_trd + AW'(1);
      if (w_push) r_tl <= r_tl + AW'(1);
      if (w_fpop) r_hd <= r_hd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_fpop);
      r_out   <= r_out + CW'(w_acc) - CW'(w_keep);
      r_disc  <= r_disc - CW'(imem.imemRspValid && r_disc != '0);
    end
  end
  always_ff @(posedge clk) begin
    if (w_acc) r_tag[r_twr] <= r_pc;
    if (w_push && !rst) r_word[r_tl] <= imem.imemRspData;
    if (w_push && !rst) r_wpc[r_tl] <= r_tag[r_trd];
    if (!rst) assert (!(w_push && !w_fpop && r_count == CW'(QDEPTH)));
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed corner sequences and random traffic against a queue-level model.
module tb_fetch_queue;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int QD = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic clk = 1'b0, rst = 1'b1, stallD = 1'b0, redirectE = 1'b0;
  logic [31:0] pcTargetE = '0;
  logic [31:0] instrD, pcD, pcPlus4D;
  logic validD;
  fetch_queue_if imem();
  fetch_queue #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .imem(imem.master), .stallD(stallD), .redirectE(redirectE),
    .pcTargetE(pcTargetE), .instrD(instrD), .pcD(pcD), .pcPlus4D(pcPlus4D), .validD(validD));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int due; bit stale;} mreq_t;
  typedef struct {logic [31:0] w; logic [31:0] pc;} ent_t;
  typedef struct {bit r; bit s; bit rd; bit rdy; logic [31:0] t; bit ereq; logic [31:0] eaddr; bit ev; logic [31:0] epc;} vec_t;
  mreq_t memq[$];
  ent_t  fq[$];
  logic [31:0] m_pc = RPC;
  int cyc = 0, lat = 1, last_due = 0, vec = 0, errs = 0;
  bit known = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at t=%0t", n, a, e, $time);
    end
  endtask
  function automatic int live();
    int n = 0;
    foreach (memq[i]) if (!memq[i].stale) n++;
    return n;
  endfunction
  function automatic bit m_req();
    return !rst && !redirectE && (fq.size() + live() < QD);
  endfunction
  function automatic bit m_byp();
`ifdef FETCH_BYPASS_EN
    return fq.size() == 0 && imem.imemRspValid && memq.size() > 0 && !memq[0].stale;
`else
    return 1'b0;
`endif
  endfunction
  function automatic ent_t m_head();
    ent_t h;
    if (fq.size() > 0) return fq[0];
    h.w = imem.imemRspData;
    h.pc = memq[0].addr;
    return h;
  endfunction
  always @(negedge clk) if (known) begin
    bit v;
    ent_t h;
    v = fq.size() > 0 || m_byp();
    chk("model_reqValid", imem.imemReqValid, m_req());
    if (m_req()) chk("model_imemAddr", imem.imemAddr, m_pc);
    chk("model_validD", validD, v);
    if (v) begin
      h = m_head();
      chk("model_instrD", instrD, h.w);
      chk("model_pcD", pcD, h.pc);
      chk("model_pcPlus4D", pcPlus4D, h.pc + 32'd4);
    end else chk("model_instrD_nop", instrD, NOP);
  end
  always @(posedge clk) begin
    bit acc, lv, byp, pop;
    mreq_t r;
    if (rst) begin
      m_pc = RPC;
      fq.delete();
      memq.delete();
      last_due = 0;
      known = 1;
    end else begin
      acc = m_req() && imem.imemReqReady;
      byp = m_byp();
      pop = (fq.size() > 0 || byp) && !stallD && !redirectE;
      lv = 0;
      if (imem.imemRspValid && memq.size() > 0) begin
        r = memq.pop_front();
        lv = !r.stale;
      end
      if (redirectE) begin
        fq.delete();
        foreach (memq[i]) memq[i].stale = 1;
        m_pc = {pcTargetE[31:2], 2'b00};
      end else begin
        if (pop && fq.size() > 0) void'(fq.pop_front());
        if (lv && !(byp && pop)) fq.push_back('{r.addr ^ KEY, r.addr});
        if (acc) begin
          last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
          memq.push_back('{m_pc, last_due, 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
    #1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem.imemRspValid = 1'b1;
      imem.imemRspData = memq[0].addr ^ KEY;
    end else begin
      imem.imemRspValid = 1'b0;
      imem.imemRspData = $urandom;
    end
  end
  task automatic drv(input bit r, input bit s, input bit rd, input bit rdy, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst = r;
    stallD = s;
    redirectE = rd;
    imem.imemReqReady = rdy;
    pcTargetE = t;
  endtask
  task automatic wait_valid(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < n && !ok; i++) begin
      drv(0, 0, 0, 1, 0);
      @(negedge clk);
      ok = validD;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[9];
    bit ok;
    imem.imemReqReady = 1'b1;
    imem.imemRspValid = 1'b0;
    imem.imemRspData = '0;
    tbl[0] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 1, 0, 1, 32'h100, 0, 0};
    tbl[2] = '{0, 0, 0, 1, 0, 1, 32'h104, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 0, 0, 0, 1, 32'h100};
    tbl[4] = '{0, 0, 0, 1, 0, 1, 32'h108, 1, 32'h104};
    tbl[5] = '{0, 0, 0, 1, 0, 1, 32'h10C, 0, 0};
    tbl[6] = '{0, 0, 0, 1, 0, 0, 0, 1, 32'h108};
    tbl[7] = '{0, 0, 0, 1, 0, 1, 32'h110, 1, 32'h10C};
    tbl[8] = '{0, 0, 0, 1, 0, 1, 32'h114, 0, 0};
`ifndef FETCH_BYPASS_EN
    foreach (tbl[i]) begin
      drv(tbl[i].r, tbl[i].s, tbl[i].rd, tbl[i].rdy, tbl[i].t);
      @(negedge clk);
      chk("tbl_reqValid", imem.imemReqValid, tbl[i].ereq);
      if (tbl[i].ereq) chk("tbl_imemAddr", imem.imemAddr, tbl[i].eaddr);
      chk("tbl_validD", validD, tbl[i].ev);
      chk("tbl_pcD", pcD, tbl[i].epc);
      chk("tbl_pcPlus4D", pcPlus4D, tbl[i].epc + 32'd4);
      chk("tbl_instrD", instrD, tbl[i].ev ? tbl[i].epc ^ KEY : NOP);
    end
`else
    foreach (tbl[i]) drv(tbl[i].r, tbl[i].s, tbl[i].rd, tbl[i].rdy, tbl[i].t);
`endif
    for (int i = 0; i < 6; i++) drv(0, 1, 0, 1, 0);
    @(negedge clk);
    chk("stall_credits_exhausted", imem.imemReqValid, 0);
    chk("stall_head_valid", validD, 1);
    lat = 2;
    for (int i = 0; i < 5; i++) drv(0, 0, 0, 1, 0);
    drv(0, 0, 1, 1, 32'h2002);
    @(negedge clk);
    chk("redir_no_req", imem.imemReqValid, 0);
    drv(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("redir_req", imem.imemReqValid, 1);
    chk("redir_addr", imem.imemAddr, 32'h2000);
    wait_valid(12, ok);
    chk("redir_timeout", ok, 1);
    chk("redir_pcD", pcD, 32'h2000);
    chk("redir_instrD", instrD, 32'h2000 ^ KEY);
    lat = 1;
    drv(0, 0, 1, 1, 32'h3000);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("bp_req", imem.imemReqValid, 1);
      chk("bp_addr", imem.imemAddr, 32'h3000);
    end
    drv(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("bp_accept_addr", imem.imemAddr, 32'h3000);
    drv(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("bp_next_addr", imem.imemAddr, 32'h3004);
    drv(0, 0, 1, 1, 32'hFFFF_FFFC);
    drv(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("wrap_addr0", imem.imemAddr, 32'hFFFF_FFFC);
    drv(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("wrap_req1", imem.imemReqValid, 1);
    chk("wrap_addr1", imem.imemAddr, 32'h0000_0000);
    wait_valid(8, ok);
    chk("wrap_timeout", ok, 1);
    chk("wrap_pcD", pcD, 32'hFFFF_FFFC);
    chk("wrap_pcPlus4D", pcPlus4D, 32'h0000_0000);
    for (int i = 0; i < 5; i++) drv(0, 1, 0, 1, 0);
    drv(1, 1, 0, 1, 0);
    @(negedge clk);
    chk("rst_req_low", imem.imemReqValid, 0);
    drv(1, 0, 0, 1, 0);
    @(negedge clk);
    chk("rst_validD", validD, 0);
    chk("rst_req_low2", imem.imemReqValid, 0);
    chk("rst_instrD", instrD, NOP);
    drv(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("rst_restart_req", imem.imemReqValid, 1);
    chk("rst_restart_addr", imem.imemAddr, RPC);
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lat = $urandom_range(1, 3);
      drv($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) < 7,
          ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom));
    end
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 1, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
